// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multicycle data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned LAT_W = 4;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmemState;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module dmem_array #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, response after LATENCY cycles,
// with a stall output that holds the pipeline until the access completes.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        stall
);

  dmemState               stateQ, stateD;
  logic [LAT_W-1:0]       cntQ, cntD;
  logic [31:0]            rdataQ;
  logic                   misQ;
  logic                   accept;
  logic                   isMis;
  logic                   memWe;
  logic [31:0]            memRdata;
  logic [DEPTH_LOG2-1:0]  wordAddr;
  logic                   unusedAddr;

  // Upper address bits are dropped, so addresses wrap over the array.
  assign wordAddr   = req_addr[DEPTH_LOG2+1:2];
  assign unusedAddr = ^req_addr[31:DEPTH_LOG2+2];
  assign isMis      = |(req_addr[1:0] & MISALIGN_MASK);
  assign accept     = (stateQ == IDLE) && req_valid;
  // Reset wins over a same-cycle acceptance, including the store commit.
  assign memWe      = accept && req_write && !isMis && !reset;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uArray (
    .clk  (clk),
    .we   (memWe),
    .addr (wordAddr),
    .wdata(req_wdata),
    .rdata(memRdata)
  );

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      IDLE: begin
        if (req_valid) begin
          cntD   = LAT_W'(LATENCY - 1);
          stateD = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cntQ == LAT_W'(1)) begin
          stateD = RESP;
        end else begin
          cntD = cntQ - LAT_W'(1);
        end
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      rdataQ <= '0;
      misQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        misQ   <= isMis;
        rdataQ <= (req_write || isMis) ? 32'h0 : memRdata;
      end
    end
  end

  assign req_ready  = (stateQ == IDLE);
  assign resp_valid = (stateQ == RESP);
  assign resp_rdata = rdataQ;
  assign misalign   = misQ;
  assign stall      = accept || (stateQ == WAIT);

endmodule
